// File: rtl/execute.sv
// Execute stage: captures an operation, evaluates it over one or two cycles,
// and holds the result until the controller drops en. The optional carry
// output is enabled by defining EXECUTE_CARRY_EN.
module execute #(
   parameter logic [1:0] OP_NOP = 2'b00,
   parameter logic [1:0] OP_LOD = 2'b01,
   parameter logic [1:0] OP_STR = 2'b10,
   parameter logic [1:0] OP_ADD = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] op,
   input  logic       srcdst,
   input  logic [7:0] imm,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] val,
   output logic [1:0] wb_op,
   output logic       wb_srcdst,
   output logic       ready
`ifdef EXECUTE_CARRY_EN
   ,
   output logic       carry
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      ADDHI = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_op;
   logic       r_srcdst;
   logic [7:0] r_imm;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_val;
   logic       r_ready;
   logic       r_nc;
   logic [4:0] w_lo_sum;
   logic [4:0] w_hi_sum;
`ifdef EXECUTE_CARRY_EN
   logic       r_carry;
`endif

   // The add is split into nibbles so each cycle only carries a 4-bit adder.
   assign w_lo_sum = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]};
   assign w_hi_sum = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + {4'b0000, r_nc};

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the statements are written in.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // NOTE: w_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (en) w_next = EXEC;
         EXEC:    if (!en)                 w_next = IDLE;
                  else if (r_op == OP_ADD) w_next = ADDHI;
                  else                     w_next = DONE;
         ADDHI:   w_next = en ? DONE : IDLE;
         DONE:    if (!en) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= OP_NOP;
         r_srcdst <= 1'b0;
         r_imm    <= 8'h00;
         r_a      <= 8'h00;
         r_b      <= 8'h00;
         r_val    <= 8'h00;
         r_ready  <= 1'b0;
         r_nc     <= 1'b0;
`ifdef EXECUTE_CARRY_EN
         r_carry  <= 1'b0;
`endif
      end else begin
         // ready is high exactly while the FSM sits in DONE.
         r_ready <= (w_next == DONE);
         if (r_state == IDLE && en) begin
            r_op     <= op;
            r_srcdst <= srcdst;
            r_imm    <= imm;
            r_a      <= a;
            r_b      <= b;
         end
         if (r_state == EXEC && en) begin
            case (r_op)
               OP_LOD:  r_val <= r_imm;
               OP_STR:  r_val <= r_srcdst ? r_b : r_a;
               OP_ADD:  {r_nc, r_val[3:0]} <= w_lo_sum;
               default: r_val <= r_val;
            endcase
         end
         if (r_state == ADDHI && en) begin
            r_val[7:4] <= w_hi_sum[3:0];
`ifdef EXECUTE_CARRY_EN
            r_carry    <= w_hi_sum[4];
`endif
         end
      end
   end

   assign val       = r_val;
   assign wb_op     = r_op;
   assign wb_srcdst = r_srcdst;
   assign ready     = r_ready;
`ifdef EXECUTE_CARRY_EN
   assign carry     = r_carry;
`endif

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: reset, LOD/STR/NOP/ADD, hold, abort
// and mid-operation reset, with hand-computed expectations.
module tb_execute;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] op;
   logic       srcdst;
   logic [7:0] imm;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] val;
   logic [1:0] wb_op;
   logic       wb_srcdst;
   logic       ready;
`ifdef EXECUTE_CARRY_EN
   logic       carry;
`endif

   int vectors = 0;
   int miscompares = 0;

   execute dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .op        (op),
      .srcdst    (srcdst),
      .imm       (imm),
      .a         (a),
      .b         (b),
      .val       (val),
      .wb_op     (wb_op),
      .wb_srcdst (wb_srcdst),
      .ready     (ready)
`ifdef EXECUTE_CARRY_EN
      ,
      .carry     (carry)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e_val, input logic [1:0] e_op,
                          input logic e_sd, input logic e_rdy);
      chk({tag, ".val"}, val, e_val);
      chk({tag, ".wb_op"}, {6'b0, wb_op}, {6'b0, e_op});
      chk({tag, ".wb_srcdst"}, {7'b0, wb_srcdst}, {7'b0, e_sd});
      chk({tag, ".ready"}, {7'b0, ready}, {7'b0, e_rdy});
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; op = 2'b00; srcdst = 1'b0;
      imm = 8'h00; a = 8'h00; b = 8'h00;
      step();
      rst = 1'b0;
      chk_all("reset", 8'h00, 2'b00, 1'b0, 1'b0);
      step();
      chk_all("idle", 8'h00, 2'b00, 1'b0, 1'b0);

      // LOD into b, imm 5A
      op = 2'b01; srcdst = 1'b1; imm = 8'h5A; a = 8'h11; b = 8'h22; en = 1'b1;
      step();
      chk_all("lod_e1", 8'h00, 2'b01, 1'b1, 1'b0);
      op = 2'b00; srcdst = 1'b0; imm = 8'hFF;
      step();
      chk_all("lod_e2", 8'h5A, 2'b01, 1'b1, 1'b1);
      step();
      chk_all("lod_hold", 8'h5A, 2'b01, 1'b1, 1'b1);
      en = 1'b0;
      step();
      chk_all("lod_drop", 8'h5A, 2'b01, 1'b1, 1'b0);

      // ADD F8 + 0C = 104 -> 04, carry 1
      op = 2'b11; srcdst = 1'b0; a = 8'hF8; b = 8'h0C; en = 1'b1;
      step();
      chk("add1_e1.ready", {7'b0, ready}, 8'h00);
      a = 8'h00; b = 8'h00;
      step();
      chk("add1_e2.ready", {7'b0, ready}, 8'h00);
      chk("add1_e2.val_partial", val, 8'h54);
      step();
      chk_all("add1_e3", 8'h04, 2'b11, 1'b0, 1'b1);
`ifdef EXECUTE_CARRY_EN
      chk("add1.carry", {7'b0, carry}, 8'h01);
`endif
      en = 1'b0;
      step();
      chk("add1_drop.ready", {7'b0, ready}, 8'h00);

      // ADD 12 + 34 = 46
      a = 8'h12; b = 8'h34; en = 1'b1;
      step(); step();
      chk("add2_e2.ready", {7'b0, ready}, 8'h00);
      step();
      chk_all("add2_e3", 8'h46, 2'b11, 1'b0, 1'b1);
`ifdef EXECUTE_CARRY_EN
      chk("add2.carry", {7'b0, carry}, 8'h00);
`endif
      en = 1'b0;
      step();

      // STR a, inputs changed after capture
      op = 2'b10; srcdst = 1'b0; a = 8'h77; b = 8'h99; en = 1'b1;
      step();
      a = 8'h00; b = 8'h00; srcdst = 1'b1;
      step();
      chk_all("str_a", 8'h77, 2'b10, 1'b0, 1'b1);
`ifdef EXECUTE_CARRY_EN
      chk("str.carry_held", {7'b0, carry}, 8'h00);
`endif
      en = 1'b0;
      step();

      // STR b
      op = 2'b10; srcdst = 1'b1; a = 8'h01; b = 8'h99; en = 1'b1;
      step(); step();
      chk_all("str_b", 8'h99, 2'b10, 1'b1, 1'b1);
      en = 1'b0;
      step();

      // NOP holds val
      op = 2'b00; srcdst = 1'b0; a = 8'hAA; imm = 8'hBB; en = 1'b1;
      step(); step();
      chk_all("nop", 8'h99, 2'b00, 1'b0, 1'b1);
      en = 1'b0;
      step();

      // ADD 0F + 01 aborted in ADDHI: low nibble written (0), high kept (9)
      op = 2'b11; a = 8'h0F; b = 8'h01; en = 1'b1;
      step(); step();
      chk("abort_e2.ready", {7'b0, ready}, 8'h00);
      en = 1'b0;
      step();
      chk("abort.ready", {7'b0, ready}, 8'h00);
      chk("abort.val_partial", val, 8'h90);
      step();
      chk("abort_idle.ready", {7'b0, ready}, 8'h00);
      // A fresh LOD completing in two edges shows the FSM returned to IDLE
      op = 2'b01; imm = 8'h3C; en = 1'b1;
      step(); step();
      chk_all("post_abort_lod", 8'h3C, 2'b01, 1'b0, 1'b1);
      en = 1'b0;
      step();

      // Reset while in EXEC of an ADD
      op = 2'b11; srcdst = 1'b1; a = 8'hFF; b = 8'hFF; en = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk_all("rst_mid", 8'h00, 2'b00, 1'b0, 1'b0);
`ifdef EXECUTE_CARRY_EN
      chk("rst_mid.carry", {7'b0, carry}, 8'h00);
`endif
      rst = 1'b0; en = 1'b0;
      step();
      chk_all("rst_after", 8'h00, 2'b00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
